// File: rtl/snap_capture_buf_pkg.sv
// Shared widths and pointer helper for the snapshot capture buffer.
package snap_capture_pkg;

  localparam int unsigned SEQ_W   = 32;
  localparam int unsigned DROP_W  = 16;
  localparam int unsigned DECIM_W = 8;

  // Advance a FIFO pointer, wrapping from depth-1 back to 0 (depth need not be a power of two).
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/snap_fifo_mem.sv
// Sample storage: one write port at wr_ptr, asynchronous read at rd_ptr. Contents are never cleared.
module snap_fifo_mem
  import snap_capture_pkg::*;
#(
  parameter int unsigned SIG_W = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_ptr_i,
  input  logic [SIG_W-1:0] wr_sig_i,
  input  longint           wr_ints_i  [NCH],
  input  real              wr_reals_i [NCH],
  input  logic [SEQ_W-1:0] wr_seq_i,
  input  logic [PTR_W-1:0] rd_ptr_i,
  output logic [SIG_W-1:0] rd_sig_o,
  output longint           rd_ints_o  [NCH],
  output real              rd_reals_o [NCH],
  output logic [SEQ_W-1:0] rd_seq_o
);

  logic [SIG_W-1:0] sig_mem   [DEPTH];
  longint           ints_mem  [DEPTH][NCH];
  real              reals_mem [DEPTH][NCH];
  logic [SEQ_W-1:0] seq_mem   [DEPTH];

  // Write one complete sample (all channels plus its tag) into the slot at wr_ptr.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      sig_mem[wr_ptr_i] <= wr_sig_i;
      seq_mem[wr_ptr_i] <= wr_seq_i;
      for (int unsigned k = 0; k < NCH; k++) begin
        ints_mem[wr_ptr_i][k]  <= wr_ints_i[k];
        reals_mem[wr_ptr_i][k] <= wr_reals_i[k];
      end
    end
  end

  // Combinational read of the head slot for first-word fall-through.
  always_comb begin
    rd_sig_o = sig_mem[rd_ptr_i];
    rd_seq_o = seq_mem[rd_ptr_i];
    for (int unsigned k = 0; k < NCH; k++) begin
      rd_ints_o[k]  = ints_mem[rd_ptr_i][k];
      rd_reals_o[k] = reals_mem[rd_ptr_i][k];
    end
  end

endmodule

// File: rtl/snap_capture_buf.sv
// Decimating snapshot buffer: samples inputs on a programmable tick, tags each attempt
// with a sequence number, stores into a FIFO and presents the head on a valid/ready port.
module snap_capture_buf
  import snap_capture_pkg::*;
#(
  parameter int unsigned SIG_W = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         clr,
  input  logic                         cap_en,
  input  logic [DECIM_W-1:0]           decim,
  input  logic [SIG_W-1:0]             logic_sig,
  input  longint                       unpacked_ints  [NCH],
  input  real                          unpacked_reals [NCH],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SIG_W-1:0]             out_sig,
  output longint                       out_ints  [NCH],
  output real                          out_reals [NCH],
  output logic [SEQ_W-1:0]             out_seq,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic [DROP_W-1:0]            drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DECIM_W-1:0] dec_cnt_q, dec_cnt_d, period_q, period_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               ovf_q, ovf_d;

  logic               tick, push, pop, drop, flush;
  logic [DECIM_W-1:0] eff_decim, period;
  logic [DECIM_W:0]   dec_nxt;

  logic [SIG_W-1:0]   head_sig;
  longint             head_ints  [NCH];
  real                head_reals [NCH];
  logic [SEQ_W-1:0]   head_seq;

  // The period is latched on each tick so a decim change only applies from the next wrap.
  always_comb begin
    flush     = !rstb || clr;
    eff_decim = (decim == '0) ? DECIM_W'(1) : decim;
    tick      = cap_en && (dec_cnt_q == '0);
    period    = tick ? eff_decim : period_q;
    pop       = (count_q != '0) && out_ready;
    push      = tick && ((count_q != CNT_W'(DEPTH)) || pop);
    drop      = tick && !push;
    dec_nxt   = {1'b0, dec_cnt_q} + 1'b1;

    dec_cnt_d = '0;
    if (cap_en && (dec_nxt != {1'b0, period}))
      dec_cnt_d = dec_nxt[DECIM_W-1:0];
    period_d  = period;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    wr_ptr_d = push ? PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;
    rd_ptr_d = pop  ? PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH)) : rd_ptr_q;
    seq_d    = tick ? seq_q + 1'b1 : seq_q;
    drop_d   = (drop && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;
    ovf_d    = ovf_q | drop;
  end

  // Control state; reset and clr give the identical cleared state.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dec_cnt_q <= '0;
      period_q  <= DECIM_W'(1);
      seq_q     <= '0;
      drop_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dec_cnt_q <= dec_cnt_d;
      period_q  <= period_d;
      seq_q     <= seq_d;
      drop_q    <= drop_d;
      ovf_q     <= ovf_d;
    end
  end

  snap_fifo_mem #(
    .SIG_W (SIG_W),
    .NCH   (NCH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk        (clk),
    .wr_en_i    (push && !flush),
    .wr_ptr_i   (wr_ptr_q),
    .wr_sig_i   (logic_sig),
    .wr_ints_i  (unpacked_ints),
    .wr_reals_i (unpacked_reals),
    .wr_seq_i   (seq_q),
    .rd_ptr_i   (rd_ptr_q),
    .rd_sig_o   (head_sig),
    .rd_ints_o  (head_ints),
    .rd_reals_o (head_reals),
    .rd_seq_o   (head_seq)
  );

  // Present the head entry, forcing all data to zero while the FIFO is empty.
  always_comb begin
    out_valid = (count_q != '0);
    out_sig   = out_valid ? head_sig : '0;
    out_seq   = out_valid ? head_seq : '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      out_ints[k]  = out_valid ? head_ints[k]  : 64'sd0;
      out_reals[k] = out_valid ? head_reals[k] : 0.0;
    end
    count    = count_q;
    overflow = ovf_q;
    drop_cnt = drop_q;
  end

endmodule
